sw_bounce_gen: RTL

- Switch-bounce emulator; the transmit side of the switch debouncer interface.
- Takes a clean level and drives a pseudo-random bouncing waveform that settles to that level.
- Used in on-board self-test and benches to feed the debouncer without a physical switch.
- Contains a µs tick prescaler, a 16-bit LFSR, and a bounce/settle FSM.

---
 rtl/sw_bounce_pkg.sv | 19 +
 rtl/sw_bounce_gen_lfsr16.sv | 33 +++
 rtl/sw_bounce_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sw_bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator.
// Holds the FSM encoding and the LFSR polynomial/default seed.
package sw_bounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;

    // One right-shift step of the Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/sw_bounce_gen_lfsr16.sv
// 16-bit Galois LFSR that steps every cycle, with seed load.
// A zero seed would lock the register, so it is replaced by the default.
module lfsr16
    import sw_bounce_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        ld,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = lfsr_step(q_q);
        if (ld) begin
            q_d = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q_q <= LFSR_DEFAULT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sw_bounce_gen.sv
// Switch-bounce emulator: turns a clean level into a pseudo-random
// bouncing waveform that settles on that level.
module sw_bounce_gen
    import sw_bounce_pkg::*;
#(
    parameter int CLK_FREQ  = 200_000_000,
    parameter int IW        = 10,
    parameter int BW        = 3,
    parameter int SETTLE_US = 20000
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        lvl_in,
    input  logic        en,
    input  logic        seed_ld,
    input  logic [15:0] seed,
    output logic        sw_out,
    output logic        busy,
    output logic        done
);

    localparam int TICK_DIV = CLK_FREQ / 1_000_000;
    localparam int UW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SETTLE_US > 0) ? $clog2(SETTLE_US + 1) : 1;

    localparam logic [UW-1:0] US_LAST  = UW'(TICK_DIV - 1);
    localparam logic [IW:0]   IVL_ONE  = (IW+1)'(1);
    localparam logic [BW:0]   TOG_ONE  = (BW+1)'(1);
    localparam logic [SW-1:0] SET_INIT = SW'(SETTLE_US);
    localparam logic [SW-1:0] SET_ONE  = SW'(1);

    state_t        state_q, state_d;
    logic [UW-1:0] us_q, us_d;
    logic          sw_q, sw_d;
    logic          tgt_q, tgt_d;
    logic [BW:0]   tog_q, tog_d;
    logic [IW:0]   ivl_q, ivl_d;
    logic [SW-1:0] set_q, set_d;
    logic          done_q, done_d;

    logic          tick;
    logic [15:0]   lfsr;
    logic [IW:0]   ivl_rnd;
    logic [BW:0]   tog_rnd;
    logic          unused_lfsr;

    lfsr16 u_lfsr (
        .clk    (clk),
        .arst_n (arst_n),
        .ld     (seed_ld),
        .seed   (seed),
        .q      (lfsr)
    );

    assign unused_lfsr = ^lfsr;

    // Free-running microsecond prescaler, independent of the FSM.
    assign tick = (us_q == US_LAST);
    assign us_d = tick ? '0 : us_q + UW'(1);

    // Interval 1..2^IW ticks; toggle count 2k-1 written as {k-1, 1}.
    assign ivl_rnd = {1'b0, lfsr[IW-1:0]} + IVL_ONE;
    assign tog_rnd = {lfsr[15:16-BW], 1'b1};

    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        tgt_d   = tgt_q;
        tog_d   = tog_q;
        ivl_d   = ivl_q;
        set_d   = set_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lvl_in != sw_q) begin
                    if (en) begin
                        tgt_d   = lvl_in;
                        tog_d   = tog_rnd;
                        ivl_d   = ivl_rnd;
                        state_d = BOUNCE;
                    end else begin
                        sw_d = lvl_in;
                    end
                end
            end
            BOUNCE: begin
                if (tick) begin
                    if (ivl_q == IVL_ONE) begin
                        sw_d  = ~sw_q;
                        tog_d = tog_q - TOG_ONE;
                        ivl_d = ivl_rnd;
                        if (tog_q == TOG_ONE) begin
                            set_d   = SET_INIT;
                            state_d = SETTLE;
                        end
                    end else begin
                        ivl_d = ivl_q - IVL_ONE;
                    end
                end
            end
            SETTLE: begin
                sw_d = tgt_q;
                if (tick) begin
                    if (set_q <= SET_ONE) begin
                        set_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        set_d = set_q - SET_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            us_q    <= '0;
            sw_q    <= 1'b0;
            tgt_q   <= 1'b0;
            tog_q   <= '0;
            ivl_q   <= '0;
            set_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            us_q    <= us_d;
            sw_q    <= sw_d;
            tgt_q   <= tgt_d;
            tog_q   <= tog_d;
            ivl_q   <= ivl_d;
            set_q   <= set_d;
            done_q  <= done_d;
        end
    end

    assign sw_out = sw_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;

endmodule
